// File: rtl/bcd_conversion_scheduler_pkg.sv
// Shared types and constants for the BCD conversion scheduler: FSM state
// encoding, digit geometry, channel-index width and the add-3 digit correction.
package bcd_conversion_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } bcd_state_t;

   localparam int BCD_DIGITS          = 3;
   localparam int DIGIT_WIDTH         = 4;
   localparam int MAX_INPUT_BIT_WIDTH = 9;
   localparam int MAX_REQUESTERS      = 8;

   function automatic int chan_idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Double-dabble correction applied to each digit before every shift.
   function automatic logic [DIGIT_WIDTH-1:0] bcd_adjust(input logic [DIGIT_WIDTH-1:0] d);
      return (d >= 4'd5) ? (d + 4'd3) : d;
   endfunction

endpackage

// File: rtl/bcd_conversion_scheduler_if.sv
// Request/response bundle of the BCD conversion scheduler; the scheduler is
// the slave, producers/consumers (or a bench) drive the master side.
interface bcd_conversion_scheduler_if
   import bcd_conversion_scheduler_pkg::*;
#(
   parameter int INPUT_BIT_WIDTH = 8,
   parameter int REQUESTERS      = 4
);
   localparam int IDX_W = chan_idx_width(REQUESTERS);

   logic [REQUESTERS-1:0]                 ReqValid;
   logic [REQUESTERS*INPUT_BIT_WIDTH-1:0] ReqData;
   logic [REQUESTERS-1:0]                 ReqReady;
   logic                                  RespValid;
   logic                                  RespReady;
   logic [IDX_W-1:0]                      RespChannel;
   logic [DIGIT_WIDTH-1:0]                Digit2;
   logic [DIGIT_WIDTH-1:0]                Digit1;
   logic [DIGIT_WIDTH-1:0]                Digit0;
   logic                                  Busy;

   modport master (
      output ReqValid, ReqData, RespReady,
      input  ReqReady, RespValid, RespChannel, Digit2, Digit1, Digit0, Busy
   );

   modport slave (
      input  ReqValid, ReqData, RespReady,
      output ReqReady, RespValid, RespChannel, Digit2, Digit1, Digit0, Busy
   );

endinterface

// File: rtl/bcd_request_arbiter.sv
// Combinational request arbiter: fixed lowest-index priority, or rotating
// priority starting at pointer_s when BCD_SCHED_ROUND_ROBIN_EN is defined.
module bcd_request_arbiter
   import bcd_conversion_scheduler_pkg::*;
#(
   parameter int REQUESTERS = 4
)
(
   input  logic [REQUESTERS-1:0]                 req_valid_s,
`ifdef BCD_SCHED_ROUND_ROBIN_EN
   input  logic [chan_idx_width(REQUESTERS)-1:0] pointer_s,
`endif
   output logic [REQUESTERS-1:0]                 grant_s,
   output logic [chan_idx_width(REQUESTERS)-1:0] grant_idx_s,
   output logic                                  grant_any_s
);
   localparam int IDX_W = chan_idx_width(REQUESTERS);

   int   cand_s;
   logic hit_s;

   if (REQUESTERS < 1 || REQUESTERS > MAX_REQUESTERS) begin : g_bad_requesters
      $error("bcd_request_arbiter: REQUESTERS must be in 1..8");
   end

   // Scan channels in priority order; the first asserted one wins.
   always_comb begin
      grant_s     = {REQUESTERS{1'b0}};
      grant_idx_s = {IDX_W{1'b0}};
      grant_any_s = 1'b0;
      hit_s       = 1'b0;
      cand_s      = 0;
      for (int i = 0; i < REQUESTERS; i++) begin
`ifdef BCD_SCHED_ROUND_ROBIN_EN
         cand_s = int'(pointer_s) + i;
         cand_s = (cand_s >= REQUESTERS) ? (cand_s - REQUESTERS) : cand_s;
`else
         cand_s = i;
`endif
         hit_s           = !grant_any_s && req_valid_s[cand_s];
         grant_s[cand_s] = grant_s[cand_s] | hit_s;
         grant_idx_s     = hit_s ? IDX_W'(cand_s) : grant_idx_s;
         grant_any_s     = grant_any_s | hit_s;
      end
   end

endmodule

// File: rtl/bcd_conversion_scheduler.sv
// Shared sequential binary-to-BCD (double-dabble) converter with arbitrated
// requesters. Define BCD_SCHED_ROUND_ROBIN_EN for round-robin arbitration.
module bcd_conversion_scheduler
   import bcd_conversion_scheduler_pkg::*;
#(
   parameter int INPUT_BIT_WIDTH = 8,
   parameter int REQUESTERS      = 4
)
(
   input logic                       Clk,
   input logic                       nReset,
   bcd_conversion_scheduler_if.slave bus
);
   localparam int IDX_W   = chan_idx_width(REQUESTERS);
   localparam int CNT_W   = chan_idx_width(INPUT_BIT_WIDTH);
   localparam int SHIFT_W = BCD_DIGITS*DIGIT_WIDTH + INPUT_BIT_WIDTH;

   if (INPUT_BIT_WIDTH < 1 || INPUT_BIT_WIDTH > MAX_INPUT_BIT_WIDTH) begin : g_bad_width
      $error("bcd_conversion_scheduler: INPUT_BIT_WIDTH must be in 1..9");
   end

   bcd_state_t                               state_r;
   bcd_state_t                               state_nxt_s;
   logic [CNT_W-1:0]                         cnt_r;
   logic [INPUT_BIT_WIDTH-1:0]               operand_r;
   logic [BCD_DIGITS-1:0][DIGIT_WIDTH-1:0]   digit_r;
   logic [IDX_W-1:0]                         chan_r;
   logic [BCD_DIGITS-1:0][DIGIT_WIDTH-1:0]   adj_s;
   logic [SHIFT_W-1:0]                       shift_s;
   logic [INPUT_BIT_WIDTH-1:0]               operand_sel_s;
   logic [REQUESTERS-1:0]                    grant_s;
   logic [IDX_W-1:0]                         grant_idx_s;
   logic                                     grant_any_s;
   logic [REQUESTERS-1:0]                    req_ready_s;

`ifdef BCD_SCHED_ROUND_ROBIN_EN
   logic [IDX_W-1:0] ptr_r;
`endif

   bcd_request_arbiter #(
      .REQUESTERS (REQUESTERS)
   ) u_arbiter (
      .req_valid_s (bus.ReqValid),
`ifdef BCD_SCHED_ROUND_ROBIN_EN
      .pointer_s   (ptr_r),
`endif
      .grant_s     (grant_s),
      .grant_idx_s (grant_idx_s),
      .grant_any_s (grant_any_s)
   );

   // Next-state logic of the IDLE/SHIFT/DONE controller.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE:  state_nxt_s = grant_any_s ? ST_SHIFT : ST_IDLE;
         ST_SHIFT: state_nxt_s = (cnt_r == {CNT_W{1'b0}}) ? ST_DONE : ST_SHIFT;
         ST_DONE:  state_nxt_s = bus.RespReady ? ST_IDLE : ST_DONE;
         default:  state_nxt_s = ST_IDLE;
      endcase
   end

   // Add-3 correction then one-bit left shift of {digits, operand}.
   always_comb begin
      adj_s = {(BCD_DIGITS*DIGIT_WIDTH){1'b0}};
      for (int d = 0; d < BCD_DIGITS; d++) begin
         adj_s[d] = bcd_adjust(digit_r[d]);
      end
      shift_s       = {adj_s, operand_r} << 1'b1;
      operand_sel_s = bus.ReqData[int'(grant_idx_s)*INPUT_BIT_WIDTH +: INPUT_BIT_WIDTH];
   end

   // Grants are only visible while idle and out of reset.
   always_comb begin
      if (nReset && (state_r == ST_IDLE)) begin
         req_ready_s = grant_s;
      end else begin
         req_ready_s = {REQUESTERS{1'b0}};
      end
   end

   // Controller state, bit counter and conversion datapath.
   always_ff @(posedge Clk) begin
      if (!nReset) begin
         state_r   <= ST_IDLE;
         cnt_r     <= {CNT_W{1'b0}};
         operand_r <= {INPUT_BIT_WIDTH{1'b0}};
         digit_r   <= {(BCD_DIGITS*DIGIT_WIDTH){1'b0}};
         chan_r    <= {IDX_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         case (state_r)
            ST_IDLE: begin
               if (grant_any_s) begin
                  operand_r <= operand_sel_s;
                  digit_r   <= {(BCD_DIGITS*DIGIT_WIDTH){1'b0}};
                  chan_r    <= grant_idx_s;
                  cnt_r     <= CNT_W'(INPUT_BIT_WIDTH - 1);
               end
            end
            ST_SHIFT: begin
               {digit_r, operand_r} <= shift_s;
               cnt_r <= (cnt_r == {CNT_W{1'b0}}) ? {CNT_W{1'b0}} : (cnt_r - CNT_W'(1));
            end
            ST_DONE: begin
               cnt_r <= cnt_r;
            end
            default: begin
               cnt_r <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

`ifdef BCD_SCHED_ROUND_ROBIN_EN
   // Rotating priority pointer advances past the channel just served.
   always_ff @(posedge Clk) begin
      if (!nReset) begin
         ptr_r <= {IDX_W{1'b0}};
      end else if ((state_r == ST_DONE) && bus.RespReady) begin
         ptr_r <= (chan_r == IDX_W'(REQUESTERS - 1)) ? {IDX_W{1'b0}} : (chan_r + IDX_W'(1));
      end
   end
`endif

   assign bus.ReqReady    = req_ready_s;
   assign bus.RespValid   = (state_r == ST_DONE);
   assign bus.Busy        = (state_r == ST_SHIFT) || (state_r == ST_DONE);
   assign bus.RespChannel = chan_r;
   assign bus.Digit2      = digit_r[2];
   assign bus.Digit1      = digit_r[1];
   assign bus.Digit0      = digit_r[0];

endmodule

// File: doc/bcd_conversion_scheduler.md
# bcd_conversion_scheduler

Sequential binary-to-BCD conversion engine shared between several requesters. A request arbiter grants one requester at a time. An FSM runs a shift-and-add-3 (double-dabble) conversion, one input bit per clock, and presents a 3-digit BCD result with a valid/ready handshake. The block sits between multiple numeric producers (counters, sensors) and display or serial formatting logic that needs decimal digits.

## Interface
Parameters:
- INPUT_BIT_WIDTH, 8, binary operand width; legal range 1..9 so the result always fits 3 digits (max 511). Values outside the range are an elaboration error.
- REQUESTERS, 4, number of request channels; legal range 1..8.

Ports:
- Clk  input  1  the single clock; all logic is on the rising edge.
- nReset  input  1  reset, synchronous and active-low.
- ReqValid  input  REQUESTERS  per-channel request.
- ReqData  input  REQUESTERS*INPUT_BIT_WIDTH  operands; channel k occupies bits [k*W +: W].
- ReqReady  output  REQUESTERS  one-hot grant, combinational, asserted only in IDLE.
- RespValid  output  1  result available.
- RespReady  input  1  consumer accepts result.
- RespChannel  output  max(1,$clog2(REQUESTERS))  index of the channel the result belongs to.
- Digit2, Digit1, Digit0  output  4 each  BCD hundreds, tens, units.
- Busy  output  1  high in SHIFT or DONE.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If any ReqValid is set, the arbiter picks channel g and drives ReqReady[g]=1 in the same cycle.
  - On that edge the block latches ReqData[g] into the operand shift register, clears the digits, sets RespChannel=g and the bit counter to INPUT_BIT_WIDTH-1, then moves to SHIFT.
  - With no request, ReqReady is all-zero and the block stays in IDLE.
- SHIFT, each cycle:
  - Every digit ≥5 gets +3.
  - Then {Digit2,Digit1,Digit0,operand} is shifted left 1, with the operand MSB entering Digit0[0].
  - The counter decrements. When the counter is 0 on that edge, the state goes to DONE.
- DONE:
  - RespValid=1, and the digits and RespChannel are held stable.
  - When RespValid&&RespReady on an edge, the state goes to IDLE and the round-robin pointer is updated.
- Digits are updated only in SHIFT. Intermediate values are visible but meaningful only while RespValid=1.
- ReqValid is allowed to drop before a grant; a withdrawn request is not served.
- ReqData is sampled only on the grant edge. Later changes do not affect the result.
- Reset:
  - State=IDLE, counter=0, round-robin pointer=0.
  - Outputs: ReqReady=0, RespValid=0, RespChannel=0, all digits=0, Busy=0.
  - Reset mid-SHIFT or in DONE discards the conversion; no response is produced.

## Timing
- The grant is combinational from ReqValid in IDLE.
- RespValid rises exactly INPUT_BIT_WIDTH edges after the grant edge.
- Best-case throughput is one conversion per INPUT_BIT_WIDTH+2 cycles: grant, W shifts, one DONE handshake cycle. There is no IDLE bypass.
- RespReady held high in DONE gives a 1-cycle RespValid pulse. RespReady low holds DONE indefinitely, and no new grant is issued.
- Requests arriving during SHIFT/DONE wait; ReqReady stays 0.

## Configuration
- BCD_SCHED_ROUND_ROBIN_EN defined:
  - The pointer selects the lowest asserted channel at or above the pointer, wrapping modulo REQUESTERS.
  - After each completed response the pointer becomes (RespChannel+1) mod REQUESTERS, with wrap from REQUESTERS-1 to 0.
- Undefined:
  - Fixed priority; the lowest-index asserted channel always wins. The pointer register is not built.

## Structure
- A shared package holds:
  - state encoding typedef (IDLE/SHIFT/DONE);
  - BCD_DIGITS=3 and a digit-width constant of 4;
  - a localparam function for the channel-index width.
- One sub-module: bcd_request_arbiter (combinational grant from ReqValid and pointer, one-hot plus index outputs). It is instantiated once; the FSM and datapath live in the top.

## Test plan
- Single channel: ch0 requests 255 with RespReady=1 → ReqReady[0] on the first cycle, RespValid 8 edges later, digits 2/5/5, RespChannel=0.
- Boundaries: operands 0 and 9, then W=9 with 511 → 0/0/0, 0/0/9, and 5/1/1.
- Contention:
  - ch0=17, ch2=100, both held valid → fixed priority gives ch0 (0/1/7), then ch2 (1/0/0).
  - With BCD_SCHED_ROUND_ROBIN_EN and all four channels held valid → grant order 0,1,2,3,0.
- Backpressure: RespReady=0 for 20 cycles in DONE → RespValid, digits and RespChannel held stable, no ReqReady. RespReady=1 → a one-cycle handshake, then IDLE.
- Reset mid-operation: nReset low during SHIFT bit 4 → next edge gives all outputs 0 and IDLE. The reset response is synchronous; an asynchronous pulse between edges has no effect. A fresh request for 42 then yields 0/4/2.
